// File: rtl/systolic_pkg.sv
// Shared types and helpers for the weight-stationary systolic array.
package systolic_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StReady, StDrain} state_e;

  // Requantised value with its saturation flag; wide enough for any BW_ACCU <= 64.
  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } rq_t;

  // Accept-to-output latency in cycles.
  function automatic int unsigned lat(input int unsigned rows, input int unsigned cols);
    return rows + cols + 1;
  endfunction

  // Width needed to index n items (0..n-1).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width needed to count 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Arithmetic right shift (rounds toward -inf), then clamp to a signed bw_out range.
  function automatic rq_t requant(input logic signed [63:0] acc, input logic [7:0] sh,
                                  input int unsigned bw_out);
    rq_t                res;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = acc >>> sh;
    hi = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw_out - 1));
    res.sat = 1'b1;
    if (r > hi) begin
      res.val = hi;
    end else if (r < lo) begin
      res.val = lo;
    end else begin
      res.sat = 1'b0;
      res.val = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: stationary weight, activation pass-right, partial sum pass-down.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned BwAct  = 8,
  parameter int unsigned BwWet  = 8,
  parameter int unsigned BwAccu = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     w_we_i,
  input  logic signed [BwWet-1:0]  w_i,
  input  logic signed [BwAct-1:0]  a_i,
  output logic signed [BwAct-1:0]  a_o,
  input  logic signed [BwAccu-1:0] psum_i,
  output logic signed [BwAccu-1:0] psum_o
);

  logic signed [BwWet-1:0]       w_q;
  logic signed [BwAct-1:0]       a_q;
  logic signed [BwAccu-1:0]      psum_q;
  logic signed [BwAccu-1:0]      psum_d;
  logic signed [BwAct+BwWet-1:0] prod;

  assign prod   = a_i * w_q;
  assign psum_d = psum_i + BwAccu'(prod);
  assign a_o    = a_q;
  assign psum_o = psum_q;

  // Weight write on load beats; activation and partial sum advance every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_q    <= '0;
      a_q    <= '0;
      psum_q <= '0;
    end else begin
      if (w_we_i) w_q <= w_i;
      a_q    <= a_i;
      psum_q <= psum_d;
    end
  end

endmodule

// File: rtl/systolic_array_ws.sv
// Weight-stationary ROWS x COLS MAC array with input skew, output de-skew and requantisation.
module systolic_array_ws
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS    = 10,
  parameter int unsigned COLS    = 10,
  parameter int unsigned BW_ACT  = 8,
  parameter int unsigned BW_WET  = 8,
  parameter int unsigned BW_ACCU = 32,
  parameter int unsigned BW_OUT  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wet_valid,
  output logic                     wet_ready,
  input  logic [COLS*BW_WET-1:0]   wet_row,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [ROWS*BW_ACT-1:0]   act_in,
  input  logic [7:0]               res_shift_num,
  output logic                     out_valid,
  output logic [COLS*BW_OUT-1:0]   out_data,
  output logic [COLS-1:0]          out_sat
);

  localparam int unsigned Lat    = lat(ROWS, COLS);
  localparam int unsigned RowW   = idx_w(ROWS);
  localparam int unsigned InfW   = cnt_w(Lat);
  localparam int unsigned VDepth = ROWS + COLS;
  localparam logic [RowW-1:0] LastRow  = RowW'(ROWS - 1);
  localparam logic [7:0]      MaxShift = 8'(BW_ACCU - 1);

  state_e           state_q;
  logic [RowW-1:0]  row_q;
  logic [RowW-1:0]  wet_row_sel;
  logic [InfW-1:0]  inflight_q;
  logic             wet_acc;
  logic             act_acc;
  logic             empty;

  assign empty       = (inflight_q == '0);
  assign wet_acc     = wet_valid & wet_ready;
  assign act_acc     = act_valid & act_ready;
  // A beat outside LOAD always starts a fresh load at row 0.
  assign wet_row_sel = (state_q == StLoad) ? row_q : '0;

  // Handshake readies; weights take priority over activations in READY.
  always_comb begin
    wet_ready = 1'b0;
    act_ready = 1'b0;
    unique case (state_q)
      StIdle, StLoad: wet_ready = 1'b1;
      StReady: begin
        wet_ready = empty;
        act_ready = !wet_valid;
      end
      default: ;
    endcase
  end

  // Load/compute control FSM and weight row counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      row_q   <= '0;
    end else if (wet_acc) begin
      if (wet_row_sel == LastRow) begin
        state_q <= StReady;
        row_q   <= '0;
      end else begin
        state_q <= StLoad;
        row_q   <= wet_row_sel + 1'b1;
      end
    end else begin
      case (state_q)
        StReady: if (wet_valid && !empty) state_q <= StDrain;
        StDrain: if (empty) state_q <= StLoad;
        default: ;
      endcase
    end
  end

  // Vectors in flight between accept and output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
    end else if (act_acc && !out_valid) begin
      inflight_q <= inflight_q + 1'b1;
    end else if (!act_acc && out_valid) begin
      inflight_q <= inflight_q - 1'b1;
    end
  end

  logic [VDepth-1:0]        vld_q;
  logic signed [BW_ACT-1:0] act_q [ROWS];

  // Input capture stage; bubbles carry zero activations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < ROWS; i++) act_q[i] <= '0;
    end else begin
      vld_q <= {vld_q[VDepth-2:0], act_acc};
      for (int i = 0; i < ROWS; i++) act_q[i] <= act_acc ? act_in[i*BW_ACT +: BW_ACT] : '0;
    end
  end

  logic signed [BW_ACT-1:0]  a_link [ROWS][COLS+1];
  logic signed [BW_ACCU-1:0] p_link [ROWS+1][COLS];
  logic signed [BW_ACCU-1:0] col_sum [COLS];
  logic                      unused_a_last;

  for (genvar i = 0; i < ROWS; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_link[i][0] = act_q[i];
    end else begin : g_dly
      logic signed [BW_ACT-1:0] dly_q [i];
      // Row i waits i cycles so it meets the partial sums arriving from above.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < i; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= act_q[i];
          for (int k = 1; k < i; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign a_link[i][0] = dly_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_top
    assign p_link[0][j] = '0;
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      systolic_pe #(
        .BwAct (BW_ACT),
        .BwWet (BW_WET),
        .BwAccu(BW_ACCU)
      ) u_pe (
        .clk_i (clk),
        .rst_ni(reset),
        .w_we_i(wet_acc && (wet_row_sel == RowW'(i))),
        .w_i   (wet_row[j*BW_WET +: BW_WET]),
        .a_i   (a_link[i][j]),
        .a_o   (a_link[i][j+1]),
        .psum_i(p_link[i][j]),
        .psum_o(p_link[i+1][j])
      );
    end
  end

  // The rightmost activation registers have no consumer.
  always_comb begin
    unused_a_last = 1'b0;
    for (int i = 0; i < ROWS; i++) unused_a_last = unused_a_last ^ (^a_link[i][COLS]);
  end

  for (genvar j = 0; j < COLS; j++) begin : g_deskew
    localparam int unsigned D = COLS - 1 - j;
    if (D == 0) begin : g_direct
      assign col_sum[j] = p_link[ROWS][j];
    end else begin : g_dly
      logic signed [BW_ACCU-1:0] dq [D];
      // Column j is delayed so all columns of one vector line up.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < D; k++) dq[k] <= '0;
        end else begin
          dq[0] <= p_link[ROWS][j];
          for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
        end
      end
      assign col_sum[j] = dq[D-1];
    end
  end

  logic [7:0]             shift;
  rq_t                    rq [COLS];
  logic [COLS*BW_OUT-1:0] rq_data;
  logic [COLS-1:0]        rq_sat;
  logic [COLS-1:0]        unused_rq_hi;

  assign shift = (res_shift_num > MaxShift) ? MaxShift : res_shift_num;

  // Per-column shift and saturate.
  always_comb begin
    rq_data      = '0;
    rq_sat       = '0;
    unused_rq_hi = '0;
    for (int j = 0; j < COLS; j++) begin
      rq[j] = requant(64'(col_sum[j]), shift, BW_OUT);
      rq_data[j*BW_OUT +: BW_OUT] = rq[j].val[BW_OUT-1:0];
      rq_sat[j]       = rq[j].sat;
      unused_rq_hi[j] = ^rq[j].val[63:BW_OUT];
    end
  end

  // Registered output stage; data holds while no vector completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else begin
      out_valid <= vld_q[VDepth-1];
      if (vld_q[VDepth-1]) begin
        out_data <= rq_data;
        out_sat  <= rq_sat;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for systolic_array_ws with a 4x4 array.
module tb_systolic_array_ws;

  localparam int R   = 4;
  localparam int C   = 4;
  localparam int LAT = R + C + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wet_valid = 1'b0;
  logic        wet_ready;
  logic [31:0] wet_row = '0;
  logic        act_valid = 1'b0;
  logic        act_ready;
  logic [31:0] act_in = '0;
  logic [7:0]  res_shift_num = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_sat;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [31:0] oq[$];
  logic [3:0]  sq[$];
  int          cq[$];

  systolic_array_ws #(
    .ROWS(R), .COLS(C), .BW_ACT(8), .BW_WET(8), .BW_ACCU(32), .BW_OUT(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wet_valid    (wet_valid),
    .wet_ready    (wet_ready),
    .wet_row      (wet_row),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .act_in       (act_in),
    .res_shift_num(res_shift_num),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_sat      (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_valid) begin
      oq.push_back(out_data);
      sq.push_back(out_sat);
      cq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] col(input logic [31:0] d, input int j);
    return 64'($signed(d[j*8 +: 8]));
  endfunction

  function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    oq.delete();
    sq.delete();
    cq.delete();
  endtask

  task automatic wet_beat(input logic [31:0] row);
    int n = 0;
    wet_row   = row;
    wet_valid = 1'b1;
    #1;
    while (!wet_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("wet_timeout", 64'(n >= 100), 0);
    @(posedge clk);
    #1;
    wet_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    wet_beat(w0);
    wet_beat(w1);
    wet_beat(w2);
    wet_beat(w3);
  endtask

  task automatic send_act(input logic [31:0] a);
    int n = 0;
    act_in    = a;
    act_valid = 1'b1;
    #1;
    while (!act_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("act_timeout", 64'(n >= 100), 0);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    act_valid = 1'b0;
    act_in    = '0;
  endtask

  task automatic wait_outs(input int n);
    int k = 0;
    while (oq.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk("out_timeout", 64'(oq.size() < n), 0);
  endtask

  task automatic one_vec(input string tag, input logic [31:0] a, input logic [7:0] sh,
                         input int exp_val, input logic [3:0] exp_sat);
    clear_q();
    res_shift_num = sh;
    send_act(a);
    wait_outs(1);
    for (int j = 0; j < C; j++) chk(tag, col(oq[0], j), exp_val);
    chk({tag, "_sat"}, 64'(sq[0]), 64'(exp_sat));
  endtask

  task automatic run_s1(input string tag);
    clear_q();
    res_shift_num = 8'd0;
    send_act(pack4(1, 2, 3, 4));
    wait_outs(1);
    for (int j = 0; j < C; j++) chk({tag, "_data"}, col(oq[0], j), j + 1);
    chk({tag, "_sat"}, 64'(sq[0]), 0);
    chk({tag, "_latency"}, cq[0] - acc_cyc, LAT - 1);
    tick();
    tick();
    chk({tag, "_pulse"}, oq.size(), 1);
    chk({tag, "_hold"}, 64'(out_data), 64'(pack4(1, 2, 3, 4)));
  endtask

  initial begin
    int stall_bad;
    int n;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_sat", 64'(out_sat), 0);
    chk("rst_wet_ready", 64'(wet_ready), 1);
    chk("rst_act_ready", 64'(act_ready), 0);
    reset = 1'b1;
    tick();

    // 1: identity weights
    load(pack4(1, 0, 0, 0), pack4(0, 1, 0, 0), pack4(0, 0, 1, 0), pack4(0, 0, 0, 1));
    run_s1("s1");

    // 2: all-ones weights, eight back-to-back vectors
    load(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    clear_q();
    for (int v = 1; v <= 8; v++) begin
      act_in    = pack4(v, v, v, v);
      act_valid = 1'b1;
      #1;
      chk("b2b_ready", 64'(act_ready), 1);
      @(posedge clk);
      #1;
    end
    act_valid = 1'b0;
    act_in    = '0;
    wait_outs(8);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < C; j++) chk("b2b_data", col(oq[k], j), 4 * (k + 1));
    end
    chk("b2b_consecutive", cq[7] - cq[0], 7);

    // 3: saturation and shift
    load(pack4(127, 127, 127, 127), pack4(127, 127, 127, 127),
         pack4(127, 127, 127, 127), pack4(127, 127, 127, 127));
    one_vec("sat_pos", pack4(127, 127, 127, 127), 8'd0, 127, 4'hf);
    one_vec("sat_neg", pack4(-128, -128, -128, -128), 8'd0, -128, 4'hf);
    one_vec("shift9", pack4(127, 127, 127, 127), 8'd9, 126, 4'h0);
    load(pack4(1, 1, 1, 1), pack4(127, 127, 127, 127),
         pack4(127, 127, 127, 127), pack4(127, 127, 127, 127));
    one_vec("neg_round", pack4(-5, 0, 0, 0), 8'd1, -3, 4'h0);

    // 4: reload while vectors are in flight
    load(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    clear_q();
    res_shift_num = 8'd0;
    act_valid = 1'b1;
    act_in = pack4(1, 2, 3, 4);
    tick();
    act_in = pack4(2, 2, 2, 2);
    tick();
    act_in = pack4(5, 0, 0, 1);
    tick();
    act_in    = pack4(1, 2, 3, 4);
    wet_row   = pack4(1, 0, 0, 0);
    wet_valid = 1'b1;
    stall_bad = 0;
    n = 0;
    while (oq.size() < 3 && n < 100) begin
      #1;
      if (act_ready || wet_ready) stall_bad++;
      tick();
      n++;
    end
    chk("drain_stall", stall_bad, 0);
    chk("drain_timeout", 64'(n >= 100), 0);
    load(pack4(1, 0, 0, 0), pack4(0, 1, 0, 0), pack4(0, 0, 1, 0), pack4(0, 0, 0, 1));
    #1;
    chk("reload_act_ready", 64'(act_ready), 1);
    @(posedge clk);
    #1;
    act_valid = 1'b0;
    act_in    = '0;
    wait_outs(4);
    for (int j = 0; j < C; j++) begin
      chk("old_w_v1", col(oq[0], j), 10);
      chk("old_w_v2", col(oq[1], j), 8);
      chk("old_w_v3", col(oq[2], j), 6);
      chk("new_w_v4", col(oq[3], j), j + 1);
    end

    // 5: reset in the middle of a load
    wet_beat(pack4(9, 9, 9, 9));
    wet_beat(pack4(9, 9, 9, 9));
    act_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("mid_rst_act_ready", 64'(act_ready), 0);
    chk("mid_rst_wet_ready", 64'(wet_ready), 1);
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_out_data", 64'(out_data), 0);
    act_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    load(pack4(1, 0, 0, 0), pack4(0, 1, 0, 0), pack4(0, 0, 1, 0), pack4(0, 0, 0, 1));
    run_s1("post_rst");

    // 6: weight beat wins over activation in an empty READY
    clear_q();
    wet_row   = pack4(1, 0, 0, 0);
    wet_valid = 1'b1;
    act_valid = 1'b1;
    act_in    = pack4(7, 7, 7, 7);
    #1;
    chk("prio_act_ready", 64'(act_ready), 0);
    chk("prio_wet_ready", 64'(wet_ready), 1);
    tick();
    wet_valid = 1'b0;
    #1;
    chk("prio_in_load", 64'(act_ready), 0);
    act_valid = 1'b0;
    act_in    = '0;
    wet_beat(pack4(0, 1, 0, 0));
    wet_beat(pack4(0, 0, 1, 0));
    wet_beat(pack4(0, 0, 0, 1));
    for (int k = 0; k < 15; k++) tick();
    chk("prio_no_output", oq.size(), 0);
    run_s1("prio_s1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_array_ws.md
Name: systolic_array_ws

Overview:
- Parametrised weight-stationary systolic MAC array: ROWS x COLS PEs with a handshaked weight-load port and a handshaked activation stream.
- Internal input skew, output de-skew and per-column requantisation (arithmetic shift plus saturate), so one accepted activation vector yields one aligned output vector.
- Sits between the activation buffer and the output/writeback stage of the accelerator datapath.

Parameters:
ROWS, 10, PE rows (activation vector length, accumulation depth)
COLS, 10, PE columns (output vector length)
BW_ACT, 8, signed activation width
BW_WET, 8, signed weight width
BW_ACCU, 32, signed accumulator width; must be >= BW_ACT+BW_WET+clog2(ROWS), otherwise sums wrap modulo 2^BW_ACCU
BW_OUT, 8, signed requantised output width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
wet_valid  in  1  weight row beat valid
wet_ready  out  1  weight row beat accepted when valid&ready
wet_row  in  COLS x BW_WET  one weight row per beat, rows 0..ROWS-1 in order
act_valid  in  1  activation vector valid
act_ready  out  1  activation vector accepted when valid&ready
act_in  in  ROWS x BW_ACT  activation vector; element i feeds row i
res_shift_num  in  8  right-shift amount; quasi-static, changes only while the array is empty
out_valid  out  1  output vector valid, one cycle, no back-pressure
out_data  out  COLS x BW_OUT  requantised column sums
out_sat  out  COLS  per-column saturation flag

Behaviour:
- Reset (async, low): state IDLE; weights, skew/de-skew/PE registers, row counter and in-flight counter all 0; out_valid=0, out_data=0, out_sat=0.
- States: IDLE (no valid weights), LOAD, READY, DRAIN.
  - IDLE: wet_ready=1, act_ready=0. wet_valid&wet_ready -> LOAD.
  - LOAD: wet_ready=1, act_ready=0. Beat k writes row k. Beat ROWS-1 -> READY, counter resets.
  - READY: act_ready = !wet_valid, so weights win when both are valid. wet_ready = (inflight==0).
    - wet_valid with inflight>0 -> DRAIN.
    - Accepted beat with inflight==0 -> LOAD, and that beat writes row 0.
  - DRAIN: wet_ready=0, act_ready=0. When inflight==0 -> LOAD.
- The first accepted weight beat in IDLE/READY writes row 0 and the state becomes LOAD.
- Gaps between load beats are allowed; the row counter holds.
- A partial load never enters READY.
- Datapath advances every cycle. Bubbles carry valid=0 and zero activations.
- Skew: row i delayed i cycles. PE(i,j) = registered activation passed right plus registered partial sum passed down: acc(i,j) = acc(i-1,j) + a*w, full BW_ACCU signed.
- Column j is de-skewed by COLS-1-j cycles. The requant stage is registered.
- Fixed latency LAT = ROWS+COLS+1 cycles: a vector accepted at edge t gives out_valid high in the cycle after edge t+LAT-1.
- Outputs appear in acceptance order; back-to-back inputs give back-to-back outputs.
- Requant:
  - s = min(res_shift_num, BW_ACCU-1); r = acc >>> s (arithmetic, rounds toward -inf).
  - Clamp r to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1]; out_sat[j]=1 iff clamped.
  - out_data/out_sat hold their last values when out_valid=0.
- inflight: +1 on act accept, -1 on out_valid. Simultaneous events cancel. Max LAT.
- Weights change only in LOAD, so in-flight vectors always use the weights they were accepted with.

Decomposition:
- Package systolic_pkg:
  - state enum (IDLE, LOAD, READY, DRAIN)
  - function lat(ROWS,COLS)
  - clog2-derived counter widths
  - saturate/shift helper function
- Sub-module systolic_pe: one PE with weight register, activation pass-through register, partial-sum register and weight write enable.
- Skew/de-skew delay lines stay inline as generate loops.

Test Plan:
(bench: ROWS=4, COLS=4, BW_OUT=8, BW_ACCU=32)
1. Load identity weights; act [1,2,3,4]; shift 0 -> out_data [1,2,3,4], out_sat 0, out_valid exactly LAT=9 cycles after accept.
2. Weights row i = [1,1,1,1]; 8 back-to-back vectors v, v=1..8 (all elements v) -> 8 consecutive out_valid cycles, columns = 4v, in order.
3. All weights 127:
   - act all 127, shift 0 -> acc 64516, out 127, out_sat=1111.
   - act all -128 -> out -128, sat=1111.
   - act all 127, shift 9 -> out 126, sat 0.
   - act [-5,0,0,0] with w row0=1, shift 1 -> -3.
4. Stream 3 vectors, assert wet_valid on the next cycle -> act_ready=0 and wet_ready=0 until the 3rd output retires. 4-beat reload follows; the first 3 outputs use the old weights, later vectors use the new weights.
5. Assert reset after 2 load beats -> IDLE, act_ready=0, out_valid=0. A fresh full load then scenario 1 passes.
6. wet_valid and act_valid both high in READY with an empty array -> weight beat accepted, act_ready=0, state LOAD.
